// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch-target adder, iterative 32-cycle
// shift-add multiplier, and the EX/MEM pipeline register (updated on the falling edge).
module ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] PC4,
    input  logic [DATA_W-1:0] dadoRs,
    input  logic [DATA_W-1:0] dadoRt,
    input  logic [DATA_W-1:0] sinalExtendido,
    input  logic              regDst,
    input  logic              branch,
    input  logic              memRead,
    input  logic              memtoReg,
    input  logic [1:0]        ALUOp,
    input  logic              memWrite,
    input  logic              ALUSrc,
    input  logic              regWrite,
    input  logic [REG_W-1:0]  rt_mux,
    input  logic [REG_W-1:0]  rd_mux,
    input  logic [REG_W-1:0]  rs_fw,
    input  logic [REG_W-1:0]  rt_fw,
    input  logic              memwb_regWrite,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              stall,
    output logic [DATA_W-1:0] aluResult_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] dadoRt_out,
    output logic [DATA_W-1:0] branchTarget_out,
    output logic              branch_out,
    output logic              memRead_out,
    output logic              memWrite_out,
    output logic              memtoReg_out,
    output logic              regWrite_out,
    output logic [REG_W-1:0]  regDest_out
);

    localparam int unsigned          CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [5:0]           F_SLL    = 6'h00;
    localparam logic [5:0]           F_MULT   = 6'h18;
    localparam logic [5:0]           F_ADD    = 6'h20;
    localparam logic [5:0]           F_SUB    = 6'h22;
    localparam logic [5:0]           F_AND    = 6'h24;
    localparam logic [5:0]           F_OR     = 6'h25;
    localparam logic [5:0]           F_SLT    = 6'h2A;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] br_target;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_W-1:0]  dest;
    } exmem_t;

    state_t            r_state, w_state_next;
    exmem_t            r_exmem, w_exmem_next, w_exmem_alu, r_mul_tmpl;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mcand, r_mplier, r_prod;
    logic              w_mul_start, w_mul_step;
    logic              w_exmem_fwd_ok, w_memwb_fwd_ok;
    logic [DATA_W-1:0] w_fwd_rs, w_fwd_rt, w_op_b, w_alu_result, w_prod_sum;
    logic [5:0]        w_funct;
    logic [4:0]        w_shamt;
    logic              w_is_mult;

    // Operand forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
    assign w_exmem_fwd_ok = r_exmem.reg_write && (r_exmem.dest != '0);
    assign w_memwb_fwd_ok = memwb_regWrite && (memwb_rd != '0);
    assign w_fwd_rs = (w_exmem_fwd_ok && (r_exmem.dest == rs_fw)) ? r_exmem.alu_result :
                      (w_memwb_fwd_ok && (memwb_rd == rs_fw))     ? memwb_data : dadoRs;
    assign w_fwd_rt = (w_exmem_fwd_ok && (r_exmem.dest == rt_fw)) ? r_exmem.alu_result :
                      (w_memwb_fwd_ok && (memwb_rd == rt_fw))     ? memwb_data : dadoRt;

    assign w_funct   = sinalExtendido[5:0];
    assign w_shamt   = sinalExtendido[10:6];
    assign w_op_b    = ALUSrc ? sinalExtendido : w_fwd_rt;
    assign w_is_mult = (ALUOp == 2'b10) && (w_funct == F_MULT);

    always_comb begin
        w_alu_result = '0;
        case (ALUOp)
            2'b00: w_alu_result = w_fwd_rs + w_op_b;
            2'b01: w_alu_result = w_fwd_rs - w_op_b;
            2'b11: w_alu_result = w_fwd_rs | {{(DATA_W-16){1'b0}}, sinalExtendido[15:0]};
            default: begin
                case (w_funct)
                    F_ADD:   w_alu_result = w_fwd_rs + w_op_b;
                    F_SUB:   w_alu_result = w_fwd_rs - w_op_b;
                    F_AND:   w_alu_result = w_fwd_rs & w_op_b;
                    F_OR:    w_alu_result = w_fwd_rs | w_op_b;
                    F_SLT:   w_alu_result = DATA_W'($signed(w_fwd_rs) < $signed(w_op_b));
                    F_SLL:   w_alu_result = w_fwd_rt << w_shamt;
                    default: w_alu_result = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        w_exmem_alu            = '0;
        w_exmem_alu.alu_result = w_alu_result;
        w_exmem_alu.zero       = (w_alu_result == '0);
        w_exmem_alu.rt_data    = w_fwd_rt;
        w_exmem_alu.br_target  = PC4 + {sinalExtendido[DATA_W-3:0], 2'b00};
        w_exmem_alu.branch     = branch;
        w_exmem_alu.mem_read   = memRead;
        w_exmem_alu.mem_write  = memWrite;
        w_exmem_alu.mem_to_reg = memtoReg;
        w_exmem_alu.reg_write  = regWrite;
        w_exmem_alu.dest       = regDst ? rd_mux : rt_mux;
    end

    assign w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : '0);

    // Upstream holds until the edge that writes the product; a flush always releases it.
    assign stall = !reset && !flush &&
                   (((r_state == IDLE) && w_is_mult) || ((r_state == MUL) && (r_cnt != CNT_LAST)));

    always_comb begin
        w_state_next = r_state;
        w_exmem_next = '0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!flush) begin
                    if (w_is_mult) begin
                        w_state_next = MUL;
                        w_mul_start  = 1'b1;
                    end else begin
                        w_exmem_next = w_exmem_alu;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next            = IDLE;
                    w_exmem_next            = r_mul_tmpl;
                    w_exmem_next.alu_result = w_prod_sum;
                    w_exmem_next.zero       = (w_prod_sum == '0);
                end else begin
                    w_mul_step = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_exmem <= '0;
        end else begin
            r_state <= w_state_next;
            r_exmem <= w_exmem_next;
        end
    end

    // Shift-add multiplier datapath; the template carries dest/controls to the final write.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_mul_tmpl <= '0;
        end else if (w_mul_start) begin
            r_cnt      <= '0;
            r_mcand    <= w_fwd_rs;
            r_mplier   <= w_fwd_rt;
            r_prod     <= '0;
            r_mul_tmpl <= w_exmem_alu;
        end else if (w_mul_step) begin
            r_cnt    <= CNT_W'(r_cnt + 1'b1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_sum;
        end
    end

    assign aluResult_out    = r_exmem.alu_result;
    assign zero_out         = r_exmem.zero;
    assign dadoRt_out       = r_exmem.rt_data;
    assign branchTarget_out = r_exmem.br_target;
    assign branch_out       = r_exmem.branch;
    assign memRead_out      = r_exmem.mem_read;
    assign memWrite_out     = r_exmem.mem_write;
    assign memtoReg_out     = r_exmem.mem_to_reg;
    assign regWrite_out     = r_exmem.reg_write;
    assign regDest_out      = r_exmem.dest;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX/MEM writes, one task per feature.
module tb_ex_stage;

    logic        clock = 1'b1;
    logic        reset, flush;
    logic [31:0] PC4, dadoRs, dadoRt, sinalExtendido, memwb_data;
    logic        regDst, branch, memRead, memtoReg, memWrite, ALUSrc, regWrite, memwb_regWrite;
    logic [1:0]  ALUOp;
    logic [4:0]  rt_mux, rd_mux, rs_fw, rt_fw, memwb_rd;
    logic        stall, zero_out, branch_out, memRead_out, memWrite_out, memtoReg_out, regWrite_out;
    logic [31:0] aluResult_out, dadoRt_out, branchTarget_out;
    logic [4:0]  regDest_out;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        rw;
        logic [4:0]  dest;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clock(clock), .reset(reset), .flush(flush), .PC4(PC4), .dadoRs(dadoRs), .dadoRt(dadoRt),
        .sinalExtendido(sinalExtendido), .regDst(regDst), .branch(branch), .memRead(memRead),
        .memtoReg(memtoReg), .ALUOp(ALUOp), .memWrite(memWrite), .ALUSrc(ALUSrc),
        .regWrite(regWrite), .rt_mux(rt_mux), .rd_mux(rd_mux), .rs_fw(rs_fw), .rt_fw(rt_fw),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .aluResult_out(aluResult_out), .zero_out(zero_out), .dadoRt_out(dadoRt_out),
        .branchTarget_out(branchTarget_out), .branch_out(branch_out), .memRead_out(memRead_out),
        .memWrite_out(memWrite_out), .memtoReg_out(memtoReg_out), .regWrite_out(regWrite_out),
        .regDest_out(regDest_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] imm,
                                              input logic src);
        logic [31:0] bb;
        bb = src ? imm : b;
        case (op)
            2'b00: return a + bb;
            2'b01: return a - bb;
            2'b11: return a | {16'h0, imm[15:0]};
            default: case (imm[5:0])
                6'h20: return a + bb;
                6'h22: return a - bb;
                6'h24: return a & bb;
                6'h25: return a | bb;
                6'h2A: return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
                6'h00: return b << imm[10:6];
                6'h18: return a * b;
                default: return 32'd0;
            endcase
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rsi, input logic [4:0] rti,
                         input logic [4:0] rd, input logic rw);
        ALUOp = op; dadoRs = a; dadoRt = b; sinalExtendido = imm;
        rs_fw = rsi; rt_fw = rti; rt_mux = rti; rd_mux = rd; regDst = 1'b1; regWrite = rw;
        ALUSrc = 1'b0; branch = 1'b0; memRead = 1'b0; memWrite = 1'b0; memtoReg = 1'b0; PC4 = 32'h0;
    endtask

    task automatic push(input logic [31:0] res, input logic rw, input logic [4:0] dest);
        exp_t x;
        x.res = res; x.zero = (res == 32'h0); x.rw = rw; x.dest = dest;
        sb.push_back(x);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(2'b10, 32'd3, 32'd4, 32'h20, 5'd0, 5'd0, 5'd6, 1'b1);
        push(32'd7, 1'b1, 5'd6);
        step();
        e = sb.pop_front(); checks++;
        if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
            errors++;
            $display("FAIL pre_reset_add: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d",
                     aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
        end
        @(posedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({aluResult_out, zero_out, dadoRt_out, branchTarget_out, branch_out, memRead_out, memWrite_out,
             memtoReg_out, regWrite_out, regDest_out, stall} !== 109'h0) begin
            errors++;
            $display("FAIL async_reset: got res=%h rw=%b d=%0d stall=%b want all zero",
                     aluResult_out, regWrite_out, regDest_out, stall);
        end
        @(posedge clock);
        reset = 1'b0;
    endtask

    task automatic test_sub_slt();
        logic [5:0] fn [2] = '{6'h22, 6'h2A};
        logic [31:0] want [2] = '{32'hFFFF_FFFE, 32'h1};
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, 32'd5, 32'd7, {26'h0, fn[i]}, 5'd0, 5'd0, 5'd9, 1'b1);
            push(want[i], 1'b1, 5'd9);
            step();
            e = sb.pop_front(); checks++;
            if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
                errors++;
                $display("FAIL sub_slt[%0d]: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d", i,
                         aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
            end
        end
    endtask

    task automatic test_random_alu();
        logic [5:0]  fts [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
        logic [1:0]  op;
        logic [31:0] a, b, imm;
        logic        src, rw, rdst;
        logic [4:0]  rd, rt;
        for (int i = 0; i < 20; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = (i % 5 == 0) ? a : $urandom;
            imm = $urandom;
            if (op == 2'b10) imm[5:0] = fts[$urandom_range(0, 6)];
            src  = (op == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            rdst = 1'($urandom_range(0, 1));
            rd   = 5'($urandom_range(0, 31));
            rt   = 5'($urandom_range(0, 31));
            drive(op, a, b, imm, 5'd0, 5'd0, rd, rw);
            ALUSrc = src; regDst = rdst; rt_mux = rt;
            push(alu_model(op, a, b, imm, src), rw, rdst ? rd : rt);
            step();
            e = sb.pop_front(); checks++;
            if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
                errors++;
                $display("FAIL rand_alu[%0d] op=%b fn=%h: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d",
                         i, op, imm[5:0], aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
            end
        end
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 7; i++) begin
            memwb_regWrite = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
            case (i)
                0: begin drive(2'b10, 32'd10, 32'd20, 32'h20, 5'd1, 5'd2, 5'd3, 1'b1); push(32'd30, 1'b1, 5'd3); end
                1: begin drive(2'b10, 32'd0, 32'd10, 32'h22, 5'd3, 5'd1, 5'd4, 1'b1); push(32'd20, 1'b1, 5'd4); end
                2: begin
                    drive(2'b10, 32'd0, 32'd10, 32'h22, 5'd3, 5'd1, 5'd5, 1'b1);
                    memwb_regWrite = 1'b1; memwb_rd = 5'd3; memwb_data = 32'd50;
                    push(32'd40, 1'b1, 5'd5);
                end
                3: begin
                    drive(2'b10, 32'd0, 32'd1, 32'h20, 5'd5, 5'd0, 5'd6, 1'b1);
                    memwb_regWrite = 1'b1; memwb_rd = 5'd5; memwb_data = 32'd7;
                    push(32'd41, 1'b1, 5'd6);
                end
                4: begin drive(2'b10, 32'd1, 32'd0, 32'h20, 5'd0, 5'd6, 5'd7, 1'b1); push(32'd42, 1'b1, 5'd7); end
                5: begin drive(2'b10, 32'd100, 32'd0, 32'h20, 5'd0, 5'd0, 5'd0, 1'b1); push(32'd100, 1'b1, 5'd0); end
                default: begin
                    drive(2'b10, 32'd4, 32'd1, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1);
                    memwb_regWrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'd999;
                    push(32'd5, 1'b1, 5'd8);
                end
            endcase
            step();
            e = sb.pop_front(); checks++;
            if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
                errors++;
                $display("FAIL forward[%0d]: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d", i,
                         aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
            end
            if (i == 4) begin
                checks++;
                if (dadoRt_out !== 32'd41) begin
                    errors++;
                    $display("FAIL forward_store_data: got %h want %h", dadoRt_out, 32'd41);
                end
            end
        end
        memwb_regWrite = 1'b0;
    endtask

    task automatic test_branch();
        drive(2'b01, 32'h55, 32'h55, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
        PC4 = 32'h100; branch = 1'b1;
        push(32'h0, 1'b0, 5'd0);
        step();
        e = sb.pop_front(); checks++;
        if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
            errors++;
            $display("FAIL beq_result: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d",
                     aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
        end
        checks++;
        if (branchTarget_out !== 32'hFC || branch_out !== 1'b1) begin
            errors++;
            $display("FAIL beq_target: got tgt=%h br=%b want tgt=000000fc br=1", branchTarget_out, branch_out);
        end
        branch = 1'b0;
    endtask

    task automatic test_flush_single();
        drive(2'b10, 32'd1, 32'd1, 32'h20, 5'd0, 5'd0, 5'd9, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (regWrite_out !== 1'b0 || aluResult_out !== 32'h0 || regDest_out !== 5'd0) begin
            errors++;
            $display("FAIL flush_single: got res=%h rw=%b d=%0d want bubble", aluResult_out, regWrite_out, regDest_out);
        end
    endtask

    task automatic test_reset_mid_mult();
        logic leaked;
        drive(2'b10, 32'd3, 32'd5, 32'h18, 5'd0, 5'd0, 5'd12, 1'b1);
        repeat (6) step();
        @(posedge clock);
        reset = 1'b1;
        drive(2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0 || regWrite_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mult: got stall=%b rw=%b want stall=0 rw=0", stall, regWrite_out);
        end
        @(posedge clock);
        reset = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (regWrite_out !== 1'b0 || stall !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mult_leak: got leak=%b want 0", leaked);
        end
    endtask

    task automatic test_mult();
        logic [31:0] ma [3];
        logic [31:0] mb [3];
        int          n;
        logic        bubble_ok;
        ma[0] = 32'h0001_0000; mb[0] = 32'h0003_0003;
        ma[1] = 32'hFFFF_FFFF; mb[1] = 32'hFFFF_FFFF;
        ma[2] = $urandom;      mb[2] = $urandom;
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, ma[k], mb[k], 32'h18, 5'd0, 5'd0, 5'd8, 1'b1);
            push(alu_model(2'b10, ma[k], mb[k], 32'h18, 1'b0), 1'b1, 5'd8);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL mult_stall_start[%0d]: got %b want 1", k, stall);
            end
            n = 1;
            bubble_ok = 1'b1;
            for (int i = 0; i < 40; i++) begin
                step();
                if (regWrite_out !== 1'b0 || aluResult_out !== 32'h0 || regDest_out !== 5'd0) bubble_ok = 1'b0;
                if (stall !== 1'b1) break;
                n++;
            end
            checks++;
            if (n !== 32) begin
                errors++;
                $display("FAIL mult_stall_cycles[%0d]: got %0d want 32", k, n);
            end
            checks++;
            if (bubble_ok !== 1'b1) begin
                errors++;
                $display("FAIL mult_bubbles[%0d]: got non-bubble on EX/MEM while multiplying", k);
            end
            step();
            e = sb.pop_front(); checks++;
            if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
                errors++;
                $display("FAIL mult_result[%0d]: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d", k,
                         aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
            end
            drive(2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL mult_stall_after[%0d]: got %b want 0", k, stall);
            end
        end
    endtask

    task automatic test_flush_mult();
        logic leaked;
        drive(2'b10, 32'd7, 32'd9, 32'h18, 5'd0, 5'd0, 5'd10, 1'b1);
        repeat (11) step();
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_mult_stall: got %b want 0", stall);
        end
        step();
        flush = 1'b0;
        checks++;
        if (regWrite_out !== 1'b0 || aluResult_out !== 32'h0) begin
            errors++;
            $display("FAIL flush_mult_bubble: got res=%h rw=%b want bubble", aluResult_out, regWrite_out);
        end
        drive(2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_mult_idle: got stall=%b want 0", stall);
        end
        leaked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (regWrite_out !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin
            errors++;
            $display("FAIL flush_mult_leak: got leak=%b want 0", leaked);
        end
        drive(2'b10, 32'd2, 32'd3, 32'h20, 5'd0, 5'd0, 5'd11, 1'b1);
        push(32'd5, 1'b1, 5'd11);
        step();
        e = sb.pop_front(); checks++;
        if (aluResult_out !== e.res || zero_out !== e.zero || regWrite_out !== e.rw || regDest_out !== e.dest) begin
            errors++;
            $display("FAIL flush_mult_next: got res=%h z=%b rw=%b d=%0d want res=%h z=%b rw=%b d=%0d",
                     aluResult_out, zero_out, regWrite_out, regDest_out, e.res, e.zero, e.rw, e.dest);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        memwb_regWrite = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
        drive(2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        reset = 1'b0;
        test_reset();
        test_sub_slt();
        test_random_alu();
        test_forwarding();
        test_branch();
        test_flush_single();
        test_reset_mid_mult();
        test_mult();
        test_flush_mult();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
